// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode field layout, opcode constants, bubble encoding
// and the default reset PC.
package pipe_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 8;
    localparam int OPC_W       = 2;
    localparam int OPC_MSB     = INSTR_W_DEF - 1;
    localparam int OPC_LSB     = INSTR_W_DEF - OPC_W;

    typedef enum logic [OPC_W-1:0] {
        OPC_ALU_REG = 2'b00,
        OPC_ALU_IMM = 2'b01,
        OPC_JUMP    = 2'b10,
        OPC_BRANCH  = 2'b11
    } opcode_e;

    localparam logic [INSTR_W_DEF-1:0] BUBBLE_INSTR     = '0;
    localparam logic [PC_W_DEF-1:0]    DEFAULT_RESET_PC = '0;

    // Any opcode with the top bit set redirects the PC.
    function automatic logic is_jump(input logic [OPC_W-1:0] opc);
        return opc[OPC_W-1];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, redirect from decode and the IF/ID outputs.
// The stall signal exists only when FETCH_STALL_EN is defined.
interface fetch_stage_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8
);
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
`ifdef FETCH_STALL_EN
    logic               stall;
`endif
    logic [INSTR_W-1:0] id_instr;
    logic [PC_W-1:0]    id_pc_plus1;
    logic               id_flushed;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  branch_taken,
        input  branch_target,
`ifdef FETCH_STALL_EN
        input  stall,
`endif
        output id_instr,
        output id_pc_plus1,
        output id_flushed
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output branch_taken,
        output branch_target,
`ifdef FETCH_STALL_EN
        output stall,
`endif
        input  id_instr,
        input  id_pc_plus1,
        input  id_flushed
    );
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program-counter register: async reset, redirect mux, hold and modulo +1 incrementer.
module pc_reg #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_target_i,
    input  logic            hold_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_plus1_o
);
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    assign pc_plus1_o = pc_q + PC_W'(1);
    assign pc_o       = pc_q;

    // Redirect outranks hold so a jump is never lost under a stall.
    always_comb begin
        pc_d = pc_plus1_o;
        if (branch_taken_i) begin
            pc_d = branch_target_i;
        end else if (hold_i) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register plus the IF/ID pipeline register with bubble on redirect.
// FETCH_STALL_EN adds the hazard-unit stall input; without it the stage never holds.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    logic               stall_w;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus1;
    logic [INSTR_W-1:0] id_instr_q,    id_instr_d;
    logic [PC_W-1:0]    id_pc_plus1_q, id_pc_plus1_d;
    logic               id_flushed_q,  id_flushed_d;

`ifdef FETCH_STALL_EN
    assign stall_w = bus.stall;
`else
    assign stall_w = 1'b0;
`endif

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst_n           (rst_n),
        .branch_taken_i  (bus.branch_taken),
        .branch_target_i (bus.branch_target),
        .hold_i          (stall_w),
        .pc_o            (pc),
        .pc_plus1_o      (pc_plus1)
    );

    assign bus.imem_addr = pc;

    // On redirect the wrong-path fetch is replaced by a bubble that decode cannot act on.
    always_comb begin
        id_instr_d    = bus.imem_rdata;
        id_pc_plus1_d = pc_plus1;
        id_flushed_d  = 1'b0;
        if (bus.branch_taken) begin
            id_instr_d    = INSTR_W'(BUBBLE_INSTR);
            id_pc_plus1_d = bus.branch_target;
            id_flushed_d  = 1'b1;
        end else if (stall_w) begin
            id_instr_d    = id_instr_q;
            id_pc_plus1_d = id_pc_plus1_q;
            id_flushed_d  = id_flushed_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_instr_q    <= INSTR_W'(BUBBLE_INSTR);
            id_pc_plus1_q <= '0;
            id_flushed_q  <= 1'b1;
        end else begin
            id_instr_q    <= id_instr_d;
            id_pc_plus1_q <= id_pc_plus1_d;
            id_flushed_q  <= id_flushed_d;
        end
    end

    assign bus.id_instr    = id_instr_q;
    assign bus.id_pc_plus1 = id_pc_plus1_q;
    assign bus.id_flushed  = id_flushed_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; stall cases run only with FETCH_STALL_EN.
module tb_fetch_stage;
    logic clk;
    logic rst_n;
    logic [7:0] imem [256];
    int checks;
    int failures;

    fetch_stage_if #(.PC_W(8), .INSTR_W(8)) bus ();

    fetch_stage #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.imem_rdata = imem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_if(input string tag, input logic [7:0] addr, input logic [7:0] instr,
                             input logic [7:0] pcp1, input logic flushed);
        check({tag, ".addr"},    bus.imem_addr,          addr);
        check({tag, ".instr"},   bus.id_instr,           instr);
        check({tag, ".pcp1"},    bus.id_pc_plus1,        pcp1);
        check({tag, ".flushed"}, 8'(bus.id_flushed),     8'(flushed));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 8'h00;
`ifdef FETCH_STALL_EN
        bus.stall = 1'b0;
`endif
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        imem[0] = 8'h12;

        // Reset and first fetch
        step();
        step();
        rst_n = 1'b1;
        expect_if("reset", 8'h00, 8'h00, 8'h00, 1'b1);
        step();
        expect_if("first", 8'h01, 8'h12, 8'h01, 1'b0);

        // Sequential fetch from a fresh reset
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) imem[i] = 8'(i + 'h40);
        imem[8'h20] = 8'hA5;
        imem[8'h21] = 8'hA6;
        imem[8'hFF] = 8'h5A;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            expect_if("seq", 8'(k + 1), 8'(k + 'h40), 8'(k + 1), 1'b0);
        end
        step();
        expect_if("seq4", 8'h05, 8'h44, 8'h05, 1'b0);

        // Taken jump at pc=5 -> one bubble, then target instruction
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h20;
        step();
        bus.branch_taken  = 1'b0;
        expect_if("jump.bubble", 8'h20, 8'h00, 8'h20, 1'b1);
        step();
        expect_if("jump.target", 8'h21, 8'hA5, 8'h21, 1'b0);

        // Redirect to 6, one normal fetch brings pc to 7
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h06;
        step();
        bus.branch_taken  = 1'b0;
        step();
        expect_if("pc7", 8'h07, 8'h46, 8'h07, 1'b0);

`ifdef FETCH_STALL_EN
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_if("stall", 8'h07, 8'h46, 8'h07, 1'b0);
        end
        bus.stall = 1'b0;
        step();
        expect_if("unstall", 8'h08, 8'h47, 8'h08, 1'b0);
        bus.stall = 1'b1;
`endif
        // Branch wins over a simultaneous stall (plain branch without stall support)
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h30;
        step();
        bus.branch_taken  = 1'b0;
`ifdef FETCH_STALL_EN
        bus.stall = 1'b0;
`endif
        expect_if("stallbr", 8'h30, 8'h00, 8'h30, 1'b1);

        // Back-to-back redirects each take effect
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h10;
        step();
        bus.branch_target = 8'hFF;
        step();
        bus.branch_taken  = 1'b0;
        expect_if("b2b", 8'hFF, 8'h00, 8'hFF, 1'b1);

        // Wrap from FF to 00
        step();
        expect_if("wrap", 8'h00, 8'h5A, 8'h00, 1'b0);
        step();
        expect_if("post_wrap", 8'h01, 8'h40, 8'h01, 1'b0);

        // Mid-run async reset overrides a pending branch, no clock edge needed
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h20;
        #2;
        rst_n = 1'b0;
        #1;
        expect_if("async_rst", 8'h00, 8'h00, 8'h00, 1'b1);
        step();
        expect_if("rst_hold", 8'h00, 8'h00, 8'h00, 1'b1);
        bus.branch_taken = 1'b0;
        rst_n = 1'b1;
        step();
        expect_if("rst_resume", 8'h01, 8'h40, 8'h01, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
